// File: rtl/fifo2mem_writer_if.sv
// fifo2mem_writer_if: bundles the word stream from the AXIS-to-FIFO stage,
// the SRAM write port, the reader free-back channel and the queue status
// outputs of fifo2mem_writer. "slave" is the writer's view; "master" is the
// environment around it (upstream stage, SRAM, reader).
interface fifo2mem_writer_if #(
  parameter int DW             = 192,
  parameter int NUM_QUEUES     = 5,
  parameter int QUEUE_ID_WIDTH = 3,
  parameter int MEM_ADDR_WIDTH = 19
);
  logic [DW+9:0]               din;
  logic                        din_valid;
  logic                        output_enable;
  logic [NUM_QUEUES-1:0]       oq;
  logic                        memfull;
  logic                        mem_wr_en;
  logic [MEM_ADDR_WIDTH-1:0]   mem_wr_addr;
  logic [DW+4:0]               mem_wr_data;
  logic                        mem_wr_ready;
  logic                        rd_free_valid;
  logic [QUEUE_ID_WIDTH-1:0]   rd_free_qid;
  logic [MEM_ADDR_WIDTH-1:0]   rd_free_words;
  logic [NUM_QUEUES-1:0]       q_nonempty;
  logic                        pkt_commit;
  logic [QUEUE_ID_WIDTH-1:0]   pkt_commit_qid;

  modport master (
    output din, din_valid, oq, mem_wr_ready, rd_free_valid, rd_free_qid, rd_free_words,
    input  output_enable, memfull, mem_wr_en, mem_wr_addr, mem_wr_data,
           q_nonempty, pkt_commit, pkt_commit_qid
  );

  modport slave (
    input  din, din_valid, oq, mem_wr_ready, rd_free_valid, rd_free_qid, rd_free_words,
    output output_enable, memfull, mem_wr_en, mem_wr_addr, mem_wr_data,
           q_nonempty, pkt_commit, pkt_commit_qid
  );
endinterface

// File: rtl/fifo2mem_writer.sv
// fifo2mem_writer: writes packets from the packed word stream into per-queue
// circular regions of external SRAM. A packet becomes visible to the reader
// only when its last word is written (per-queue write pointer commit).
// Optional build macro FIFO2MEM_DROP_CNT_EN adds a saturating 32-bit
// drop_cnt output counting packets that were discarded.
module fifo2mem_writer #(
  parameter int CROPPED_DATA_WIDTH = 24,
  parameter int NUM_QUEUES         = 5,
  parameter int QUEUE_ID_WIDTH     = 3,
  parameter int MEM_ADDR_WIDTH     = 19,
  parameter int QUEUE_SIZE         = 104857,
  parameter int MAX_PKT_WORDS      = 66
) (
  input  logic             memclk,
  input  logic             memreset,
  fifo2mem_writer_if.slave bus
`ifdef FIFO2MEM_DROP_CNT_EN
  ,
  output logic [31:0]      drop_cnt
`endif
);

  localparam int DW = 8 * CROPPED_DATA_WIDTH;
  localparam int AW = MEM_ADDR_WIDTH;
  localparam int QW = QUEUE_ID_WIDTH;

  localparam logic [AW-1:0] QSIZE = AW'(QUEUE_SIZE);
  localparam logic [AW-1:0] QLAST = AW'(QUEUE_SIZE - 1);
  localparam logic [AW-1:0] MAXW  = AW'(MAX_PKT_WORDS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_HDR   = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  // Offset within a queue region, wrapping at the end of the region.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == QLAST) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [AW-1:0] base_addr(input logic [QW-1:0] q);
    return AW'(32'(q) * 32'(QUEUE_SIZE));
  endfunction

  // Occupancy release never goes below empty.
  function automatic logic [AW-1:0] sat_sub(input logic [AW-1:0] a, input logic [AW-1:0] b);
    return (b > a) ? '0 : a - b;
  endfunction

  logic [1:0]    state;
  logic [QW-1:0] qid;
  logic [AW-1:0] wptr_work;
  logic [AW-1:0] pkt_cnt;
  logic [AW-1:0] wptr_commit [NUM_QUEUES];
  logic [AW-1:0] occ         [NUM_QUEUES];
  logic [AW-1:0] occ_nxt     [NUM_QUEUES];

  logic [QW-1:0]         oq_idx;
  logic                  oe;
  logic                  xfer;
  logic                  in_pkt;
  logic                  eop;
  logic                  overflow;
  logic                  commit;
  logic                  idle_drop;
  logic [AW-1:0]         free_sel;
  logic [AW:0]           fill_next;
  logic                  full_any;
  logic [NUM_QUEUES-1:0] ne_vec;
  logic                  unused_din_bits;

  // pkg_state and the spare bit are carried by the stream but not needed here.
  assign unused_din_bits = ^{bus.din[4:2], bus.din[0]};

  assign eop    = bus.din[1];
  assign in_pkt = (state == S_HDR) || (state == S_DATA);

  // Destination queue = lowest set bit of the one-hot oq.
  always_comb begin
    oq_idx = '0;
    for (int i = NUM_QUEUES - 1; i >= 0; i--) begin
      if (bus.oq[i]) oq_idx = QW'(i);
    end
  end

  // Ready: follow the SRAM while writing, always accept while draining.
  always_comb begin
    case (state)
      S_HDR, S_DATA: oe = bus.mem_wr_ready;
      S_DRAIN:       oe = 1'b1;
      default:       oe = 1'b0;
    endcase
  end

  assign bus.output_enable = oe;
  assign xfer              = bus.din_valid && oe;
  assign bus.mem_wr_en     = xfer && in_pkt;
  assign bus.mem_wr_addr   = base_addr(qid) + wptr_work;
  assign bus.mem_wr_data   = bus.din[DW+9:5];

  // Fill level the queue would reach if this word were kept.
  assign fill_next = {1'b0, occ[qid]} + {1'b0, pkt_cnt} + 1'b1;
  assign overflow  = in_pkt && xfer && (fill_next >= {1'b0, QSIZE});
  assign commit    = (state == S_DATA) && xfer && eop && !overflow;
  assign free_sel  = QSIZE - occ[oq_idx];
  assign idle_drop = (state == S_IDLE) && bus.din_valid &&
                     ((bus.oq == '0) || (free_sel < MAXW));

  // Next occupancy: commit adds the whole packet, a release subtracts; both may hit one queue.
  always_comb begin
    for (int q = 0; q < NUM_QUEUES; q++) begin
      occ_nxt[q] = occ[q];
      if (commit && (qid == QW'(q)))
        occ_nxt[q] = occ_nxt[q] + pkt_cnt + 1'b1;
      if (bus.rd_free_valid && (bus.rd_free_qid == QW'(q)))
        occ_nxt[q] = sat_sub(occ_nxt[q], bus.rd_free_words);
    end
  end

  // Status flags derived from the current occupancies.
  always_comb begin
    full_any = 1'b0;
    ne_vec   = '0;
    for (int q = 0; q < NUM_QUEUES; q++) begin
      ne_vec[q] = (occ[q] != '0);
      if ((QSIZE - occ[q]) < MAXW) full_any = 1'b1;
    end
  end

  // Packet FSM: pick queue, write header and data, abort to drain on overflow.
  always_ff @(posedge memclk) begin
    if (memreset) begin
      state     <= S_IDLE;
      qid       <= '0;
      wptr_work <= '0;
      pkt_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.din_valid) begin
            qid       <= oq_idx;
            wptr_work <= wptr_commit[oq_idx];
            pkt_cnt   <= '0;
            state     <= idle_drop ? S_DRAIN : S_HDR;
          end
        end
        S_HDR, S_DATA: begin
          if (xfer) begin
            if (overflow) begin
              wptr_work <= wptr_commit[qid];
              state     <= eop ? S_IDLE : S_DRAIN;
            end else begin
              wptr_work <= ptr_inc(wptr_work);
              pkt_cnt   <= pkt_cnt + 1'b1;
              if (state == S_HDR) state <= S_DATA;
              else if (eop)       state <= S_IDLE;
            end
          end
        end
        S_DRAIN: begin
          if (xfer && eop) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Committed pointers and occupancies per queue.
  always_ff @(posedge memclk) begin
    if (memreset) begin
      for (int q = 0; q < NUM_QUEUES; q++) begin
        wptr_commit[q] <= '0;
        occ[q]         <= '0;
      end
    end else begin
      for (int q = 0; q < NUM_QUEUES; q++) occ[q] <= occ_nxt[q];
      if (commit) wptr_commit[qid] <= ptr_inc(wptr_work);
    end
  end

  // Registered status outputs and the commit pulse.
  always_ff @(posedge memclk) begin
    if (memreset) begin
      bus.memfull        <= 1'b0;
      bus.q_nonempty     <= '0;
      bus.pkt_commit     <= 1'b0;
      bus.pkt_commit_qid <= '0;
    end else begin
      bus.memfull    <= full_any;
      bus.q_nonempty <= ne_vec;
      bus.pkt_commit <= commit;
      if (commit) bus.pkt_commit_qid <= qid;
    end
  end

`ifdef FIFO2MEM_DROP_CNT_EN
  logic drop_evt;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // A packet is dropped on entering DRAIN from IDLE or when aborted mid-packet.
  assign drop_evt = idle_drop || overflow;

  // Saturating count of discarded packets.
  always_ff @(posedge memclk) begin
    if (memreset)      drop_cnt <= '0;
    else if (drop_evt) drop_cnt <= sat_inc32(drop_cnt);
  end
`endif

endmodule

// File: tb/tb_fifo2mem_writer.sv
// Bench for fifo2mem_writer with QUEUE_SIZE=16 and MAX_PKT_WORDS=4.
// Table rows describe one packet (or a bare release) with hand-computed
// addresses, commit, occupancy flags and drop count.
module tb_fifo2mem_writer;

  localparam int NQ = 5;
  localparam int QW = 3;
  localparam int AW = 19;
  localparam int DW = 192;
  localparam int NV = 25;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo2mem_writer_if #(.DW(DW), .NUM_QUEUES(NQ), .QUEUE_ID_WIDTH(QW), .MEM_ADDR_WIDTH(AW)) bus ();

`ifdef FIFO2MEM_DROP_CNT_EN
  logic [31:0] drop_cnt;
`endif

  fifo2mem_writer #(
    .CROPPED_DATA_WIDTH(24), .NUM_QUEUES(NQ), .QUEUE_ID_WIDTH(QW),
    .MEM_ADDR_WIDTH(AW), .QUEUE_SIZE(16), .MAX_PKT_WORDS(4)
  ) dut (
    .memclk   (clk),
    .memreset (rst),
    .bus      (bus)
`ifdef FIFO2MEM_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  typedef struct {
    logic [4:0] oq;
    int         nw;        // words in packet, 0 = release only
    int         qbase;
    int         off0;      // expected first offset in the region
    bit         accept;
    int         exp_qid;
    int         abort_at;  // index of the overflowing word, -1 none
    int         stall_at;  // word index held off by 3 not-ready cycles, -1 none
    int         free_q;
    int         free_n;
    bit         free_with_eop;
    logic [4:0] exp_ne;
    bit         exp_mf;
    int         exp_drop;
  } vec_t;

  vec_t tbl [NV];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [191:0] mk_payload(input int idx, input int k);
    return {8{8'(idx), 8'(k), 8'h5A}};
  endfunction

  task automatic do_free(input int q, input int n);
    @(posedge clk); #1;
    bus.rd_free_valid = 1'b1;
    bus.rd_free_qid   = 3'(q);
    bus.rd_free_words = 19'(n);
    @(posedge clk); #1;
    bus.rd_free_valid = 1'b0;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int   k;
    int   cyc;
    int   stalls;
    bit   xfer;
    bit   last;
    v = tbl[i];
    k = 0; cyc = 0; stalls = 0;
    if (v.nw > 0) begin
      while (k < v.nw && cyc < 100) begin
        last          = (k == v.nw - 1);
        bus.din_valid = 1'b1;
        bus.oq        = v.oq;
        bus.din       = {mk_payload(i, k), 5'(k + 1), 3'b000, last, 1'b0};
        bus.mem_wr_ready = !(v.stall_at == k && stalls < 3);
        if (v.free_with_eop && last) begin
          bus.rd_free_valid = 1'b1;
          bus.rd_free_qid   = 3'(v.free_q);
          bus.rd_free_words = 19'(v.free_n);
        end
        xfer = 1'b0;
        @(negedge clk);
        if (!bus.mem_wr_ready) begin
          chk($sformatf("r%0d stall%0d oe", i, stalls), 256'(bus.output_enable), 256'(0));
          chk($sformatf("r%0d stall%0d wr_en", i, stalls), 256'(bus.mem_wr_en), 256'(0));
          stalls++;
        end else if (bus.output_enable) begin
          xfer = 1'b1;
          if (v.accept && (v.abort_at < 0 || k <= v.abort_at)) begin
            chk($sformatf("r%0d k%0d wr_en", i, k), 256'(bus.mem_wr_en), 256'(1));
            chk($sformatf("r%0d k%0d addr", i, k), 256'(bus.mem_wr_addr),
                256'(v.qbase + ((v.off0 + k) % 16)));
            chk($sformatf("r%0d k%0d data", i, k), 256'(bus.mem_wr_data),
                256'({mk_payload(i, k), 5'(k + 1)}));
          end else begin
            chk($sformatf("r%0d k%0d drop wr_en", i, k), 256'(bus.mem_wr_en), 256'(0));
          end
        end
        @(posedge clk); #1;
        bus.rd_free_valid = 1'b0;
        if (xfer) k++;
        cyc++;
      end
      if (k < v.nw) chk($sformatf("r%0d timeout words", i), 256'(k), 256'(v.nw));
      bus.din_valid    = 1'b0;
      bus.oq           = '0;
      bus.mem_wr_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("r%0d pkt_commit", i), 256'(bus.pkt_commit),
          256'(v.accept && v.abort_at < 0));
      if (v.accept && v.abort_at < 0)
        chk($sformatf("r%0d commit_qid", i), 256'(bus.pkt_commit_qid), 256'(v.exp_qid));
    end
    if (v.free_n > 0 && !v.free_with_eop) do_free(v.free_q, v.free_n);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("r%0d commit_low", i), 256'(bus.pkt_commit), 256'(0));
    chk($sformatf("r%0d q_nonempty", i), 256'(bus.q_nonempty), 256'(v.exp_ne));
    chk($sformatf("r%0d memfull", i), 256'(bus.memfull), 256'(v.exp_mf));
`ifdef FIFO2MEM_DROP_CNT_EN
    chk($sformatf("r%0d drop_cnt", i), 256'(drop_cnt), 256'(v.exp_drop));
`endif
  endtask

  initial begin
    //          oq        nw qb  off acc qid ab  st  fq fn fe  ne        mf drop
    tbl[0]  = '{5'b00100, 3, 32, 0,  1, 2, -1, -1, 0, 0, 0, 5'b00100, 0, 0};
    tbl[1]  = '{5'b00000, 2, 0,  0,  0, 0, -1, -1, 0, 0, 0, 5'b00100, 0, 1};
    tbl[2]  = '{5'b00001, 4, 0,  0,  1, 0, -1, -1, 0, 4, 0, 5'b00100, 0, 1};
    tbl[3]  = '{5'b00011, 4, 0,  4,  1, 0, -1, -1, 0, 4, 0, 5'b00100, 0, 1};
    tbl[4]  = '{5'b00001, 4, 0,  8,  1, 0, -1, -1, 0, 4, 0, 5'b00100, 0, 1};
    tbl[5]  = '{5'b10001, 2, 0,  12, 1, 0, -1, -1, 0, 2, 0, 5'b00100, 0, 1};
    tbl[6]  = '{5'b00001, 4, 0,  14, 1, 0, -1, -1, 0, 0, 0, 5'b00101, 0, 1};
    tbl[7]  = '{5'b00001, 2, 0,  2,  1, 0, -1, -1, 0, 6, 0, 5'b00100, 0, 1};
    tbl[8]  = '{5'b00010, 4, 16, 0,  1, 1, -1, -1, 0, 0, 0, 5'b00110, 0, 1};
    tbl[9]  = '{5'b00010, 4, 16, 4,  1, 1, -1, -1, 0, 0, 0, 5'b00110, 0, 1};
    tbl[10] = '{5'b00010, 5, 16, 8,  1, 1, -1, -1, 0, 0, 0, 5'b00110, 1, 1};
    tbl[11] = '{5'b00010, 5, 16, 13, 0, 1, -1, -1, 0, 0, 0, 5'b00110, 1, 2};
    tbl[12] = '{5'b00000, 0, 0,  0,  0, 0, -1, -1, 1, 12, 0, 5'b00110, 0, 2};
    tbl[13] = '{5'b00010, 5, 16, 13, 1, 1, -1, 2,  1, 6, 0, 5'b00100, 0, 2};
    tbl[14] = '{5'b00000, 0, 0,  0,  0, 0, -1, -1, 2, 3, 0, 5'b00000, 0, 2};
    tbl[15] = '{5'b00100, 4, 32, 3,  1, 2, -1, -1, 0, 0, 0, 5'b00100, 0, 2};
    tbl[16] = '{5'b00100, 3, 32, 7,  1, 2, -1, -1, 2, 2, 1, 5'b00100, 0, 2};
    tbl[17] = '{5'b00000, 0, 0,  0,  0, 0, -1, -1, 2, 4, 0, 5'b00100, 0, 2};
    tbl[18] = '{5'b00000, 0, 0,  0,  0, 0, -1, -1, 2, 1, 0, 5'b00000, 0, 2};
    tbl[19] = '{5'b00001, 5, 0,  4,  1, 0, -1, -1, 0, 0, 0, 5'b00001, 0, 2};
    tbl[20] = '{5'b00001, 5, 0,  9,  1, 0, -1, -1, 0, 0, 0, 5'b00001, 0, 2};
    tbl[21] = '{5'b00001, 7, 0,  14, 1, 0, 5,  -1, 0, 0, 0, 5'b00001, 0, 3};
    tbl[22] = '{5'b00001, 6, 0,  14, 1, 0, 5,  -1, 0, 0, 0, 5'b00001, 0, 4};
    tbl[23] = '{5'b00001, 2, 0,  14, 1, 0, -1, -1, 0, 0, 0, 5'b00001, 0, 4};
    tbl[24] = '{5'b00000, 0, 0,  0,  0, 0, -1, -1, 0, 12, 0, 5'b00000, 0, 4};

    bus.din           = '0;
    bus.din_valid     = 1'b0;
    bus.oq            = '0;
    bus.mem_wr_ready  = 1'b1;
    bus.rd_free_valid = 1'b0;
    bus.rd_free_qid   = '0;
    bus.rd_free_words = '0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset output_enable", 256'(bus.output_enable), 256'(0));
    chk("reset mem_wr_en", 256'(bus.mem_wr_en), 256'(0));
    chk("reset memfull", 256'(bus.memfull), 256'(0));
    chk("reset q_nonempty", 256'(bus.q_nonempty), 256'(0));
    chk("reset pkt_commit", 256'(bus.pkt_commit), 256'(0));
    chk("reset pkt_commit_qid", 256'(bus.pkt_commit_qid), 256'(0));
`ifdef FIFO2MEM_DROP_CNT_EN
    chk("reset drop_cnt", 256'(drop_cnt), 256'(0));
`endif
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) run_vec(i);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
